// File: rtl/mode_select.sv
// mode_select -- smoker fan gear selector.
//
// Four raw push buttons (menu, mode1..mode3) are synchronised, edge
// detected and turned into single-cycle press pulses. The pulses drive a
// six-state FSM: STANDBY, MENU, GEAR1, GEAR2, GEAR3 (timed hurricane run)
// and EXIT_WAIT (timed run-down before standby). The hurricane gear can be
// entered only once per reset.
//
// Optional feature: define BTN_DEBOUNCE_EN to require each synchronised
// button level to stay high for DEBOUNCE_CYCLES clocks before a press is
// accepted. With the macro undefined there is no debounce logic.
//
// Ports
//   clk             system clock
//   rst             asynchronous, active-low reset
//   tick_1hz        one-cycle enable pulse per second
//   menu_btn        raw menu button, active-high
//   mode1_btn       raw gear 1 button, active-high
//   mode2_btn       raw gear 2 button, active-high
//   mode3_btn       raw gear 3 (hurricane) button, active-high
//   mode_state      gear code: 000 standby, 001 gear1, 010 gear2, 011 gear3
//   menu_active     high while in MENU
//   exit_pending    high while in EXIT_WAIT
//   hurricane_avail high until gear 3 has been entered once since reset
//   countdown_sec   seconds left in GEAR3 / EXIT_WAIT, otherwise 0
//   state_dbg       raw FSM state register, for debug and checkers
module mode_select #(
  parameter int HURRICANE_SEC   = 60,
  parameter int EXIT_SEC        = 60,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       menu_btn,
  input  logic       mode1_btn,
  input  logic       mode2_btn,
  input  logic       mode3_btn,
  output logic [2:0] mode_state,
  output logic       menu_active,
  output logic       exit_pending,
  output logic       hurricane_avail,
  output logic [6:0] countdown_sec,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    ST_STANDBY   = 3'd0,
    ST_MENU      = 3'd1,
    ST_GEAR1     = 3'd2,
    ST_GEAR2     = 3'd3,
    ST_GEAR3     = 3'd4,
    ST_EXIT_WAIT = 3'd5
  } state_t;

  localparam logic [6:0] HURRICANE_LOAD = 7'(HURRICANE_SEC);
  localparam logic [6:0] EXIT_LOAD      = 7'(EXIT_SEC);

  // Bit order of every button vector: [0] menu, [1] mode1, [2] mode2, [3] mode3.
  logic [3:0] btn_raw;
  assign btn_raw = {mode3_btn, mode2_btn, mode1_btn, menu_btn};

  // ---------------------------------------------------------------------
  // Button front end
  // ---------------------------------------------------------------------
  logic [3:0] sync1_q, sync1_d;
  logic [3:0] sync2_q, sync2_d;
  logic [3:0] lvl;                // accepted (optionally debounced) level
  logic [3:0] lvl_prev_q, lvl_prev_d;
  logic [3:0] armed_q, armed_d;
  logic [3:0] press_q, press_d;
  // valid_q[1] is set once sync2_q holds a real sample of the pins rather
  // than its reset value.
  logic [1:0] valid_q, valid_d;

  // A button is armed only after it has been seen released since reset, so
  // a button already held when reset releases produces no press.
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    valid_d    = {valid_q[0], 1'b1};
    armed_d    = armed_q | ({4{valid_q[1]}} & ~sync2_q);
    lvl_prev_d = lvl;
    press_d    = lvl & ~lvl_prev_q & armed_q;
  end

`ifdef BTN_DEBOUNCE_EN
  localparam int             CW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  DB_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] db_cnt_q [4];
  logic [CW-1:0] db_cnt_d [4];

  // Count consecutive high cycles of the synchronised level, saturating;
  // the level is accepted only once the count reaches DEBOUNCE_CYCLES.
  always_comb begin
    lvl = '0;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (!sync2_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] != DB_MAX) begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
      lvl[i] = (db_cnt_q[i] == DB_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end
`else
  // Without debounce the synchronised level is used directly; the debounce
  // length has no effect in this build.
  if (DEBOUNCE_CYCLES > 0) begin : g_direct
    assign lvl = sync2_q;
  end else begin : g_direct_zero
    assign lvl = sync2_q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      valid_q    <= '0;
      armed_q    <= '0;
      lvl_prev_q <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      valid_q    <= valid_d;
      armed_q    <= armed_d;
      lvl_prev_q <= lvl_prev_d;
      press_q    <= press_d;
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic       avail_q, avail_d;
  logic       win_menu, win_m3, win_m2, win_m1;

  // Only the highest-priority press in a cycle acts: menu > mode3 > mode2 > mode1.
  assign win_menu = press_q[0];
  assign win_m3   = press_q[3] & ~press_q[0];
  assign win_m2   = press_q[2] & ~press_q[3] & ~press_q[0];
  assign win_m1   = press_q[1] & ~press_q[2] & ~press_q[3] & ~press_q[0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    avail_d = avail_q;
    case (state_q)
      ST_STANDBY: begin
        if (win_menu) state_d = ST_MENU;
      end
      ST_MENU, ST_GEAR1, ST_GEAR2: begin
        if (win_menu) begin
          state_d = ST_STANDBY;
        end else if (win_m3) begin
          // An unavailable hurricane swallows the press entirely.
          if (avail_q) begin
            state_d = ST_GEAR3;
            cnt_d   = HURRICANE_LOAD;
            avail_d = 1'b0;
          end
        end else if (win_m2) begin
          state_d = ST_GEAR2;
        end else if (win_m1) begin
          state_d = ST_GEAR1;
        end
      end
      ST_GEAR3: begin
        // A menu press in the same cycle as a tick wins; the tick is lost.
        if (win_menu) begin
          state_d = ST_EXIT_WAIT;
          cnt_d   = EXIT_LOAD;
        end else if (tick_1hz) begin
          if (cnt_q <= 7'd1) begin
            state_d = ST_GEAR2;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
      end
      ST_EXIT_WAIT: begin
        if (tick_1hz) begin
          if (cnt_q <= 7'd1) begin
            state_d = ST_STANDBY;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q - 7'd1;
          end
        end
      end
      default: begin
        state_d = ST_STANDBY;
        cnt_d   = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_STANDBY;
      cnt_q   <= 7'd0;
      avail_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      avail_q <= avail_d;
    end
  end

  // Outputs decode the state register only; no button reaches them
  // combinationally.
  always_comb begin
    mode_state = 3'b000;
    case (state_q)
      ST_GEAR1:     mode_state = 3'b001;
      ST_GEAR2:     mode_state = 3'b010;
      ST_GEAR3:     mode_state = 3'b011;
      ST_EXIT_WAIT: mode_state = 3'b010;
      default:      mode_state = 3'b000;
    endcase
  end

  assign menu_active     = (state_q == ST_MENU);
  assign exit_pending    = (state_q == ST_EXIT_WAIT);
  assign hurricane_avail = avail_q;
  assign countdown_sec   = cnt_q;
  assign state_dbg       = state_q;

endmodule
